// File: rtl/load_extend_mux.sv
// load_extend_mux: formats AXI read data for the LSU writeback register.
// Selects the byte/halfword addressed by byte_off, applies RV32 load semantics
// (lb/lh/lw/lbu/lhu) through a keyed mux with a zero default, and publishes the
// result both combinationally and as a register captured on rvalid.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   rdata    in   raw bus read word
//   funct3   in   load type key (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
//   byte_off in   effective-address bits [1:0]
//   rvalid   in   read-data valid, capture strobe for rdata_q
//   rdata_ex out  combinational formatted result
//   key_hit  out  combinational, 1 when funct3 is one of the load keys
//   rdata_q  out  registered formatted result
module load_extend_mux #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned NR_KEY   = 5,
    parameter int unsigned KEY_LEN  = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_LEN-1:0] rdata,
    input  logic [KEY_LEN-1:0]  funct3,
    input  logic [1:0]          byte_off,
    input  logic                rvalid,
    output logic [DATA_LEN-1:0] rdata_ex,
    output logic                key_hit,
    output logic [DATA_LEN-1:0] rdata_q
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned HALF_W  = 16;
    localparam int unsigned SHIFT_W = 5;

    // Key table; entry order matches the data table built below.
    localparam logic [KEY_LEN-1:0] MUX_KEYS [NR_KEY] = '{
        KEY_LEN'(0),   // lb
        KEY_LEN'(1),   // lh
        KEY_LEN'(2),   // lw
        KEY_LEN'(4),   // lbu
        KEY_LEN'(5)    // lhu
    };

    localparam logic [DATA_LEN-1:0] DEFAULT_VAL = '0;

    // Sign-extend a byte to the full data width.
    function automatic logic [DATA_LEN-1:0] sext8(input logic [BYTE_W-1:0] v);
        return {{(DATA_LEN-BYTE_W){v[BYTE_W-1]}}, v};
    endfunction

    // Sign-extend a halfword to the full data width.
    function automatic logic [DATA_LEN-1:0] sext16(input logic [HALF_W-1:0] v);
        return {{(DATA_LEN-HALF_W){v[HALF_W-1]}}, v};
    endfunction

    // Zero-extend a byte to the full data width.
    function automatic logic [DATA_LEN-1:0] zext8(input logic [BYTE_W-1:0] v);
        return {{(DATA_LEN-BYTE_W){1'b0}}, v};
    endfunction

    // Zero-extend a halfword to the full data width.
    function automatic logic [DATA_LEN-1:0] zext16(input logic [HALF_W-1:0] v);
        return {{(DATA_LEN-HALF_W){1'b0}}, v};
    endfunction

    logic [SHIFT_W-1:0]  shift;
    logic [HALF_W-1:0]   h16;
    logic [BYTE_W-1:0]   b8;
    logic [DATA_LEN-1:0] i8;
    logic [DATA_LEN-1:0] i16;
    logic [DATA_LEN-1:0] mux_data [NR_KEY];
    logic [DATA_LEN-1:0] mux_or;
    logic [DATA_LEN-1:0] rdata_d;

    // Lane extraction: a logical right shift zero-fills, so a halfword at
    // byte_off=3 naturally reads {8'h00, rdata[31:24]}.
    assign shift = {byte_off, 3'b000};
    assign h16   = HALF_W'(rdata >> shift);
    assign b8    = h16[BYTE_W-1:0];

    assign i8    = sext8(b8);
    assign i16   = sext16(h16);

    // Candidate results, one per key.
    always_comb begin
        mux_data[0] = i8;
        mux_data[1] = i16;
        mux_data[2] = rdata;
        mux_data[3] = zext8(b8);
        mux_data[4] = zext16(h16);
    end

    // Keyed mux: keys are unique, so an AND-OR reduction needs no priority.
    always_comb begin
        key_hit = 1'b0;
        mux_or  = '0;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            if (funct3 == MUX_KEYS[i]) begin
                key_hit = 1'b1;
                mux_or  = mux_or | mux_data[i];
            end
        end
    end

    assign rdata_ex = key_hit ? mux_or : DEFAULT_VAL;

    // Capture the formatted value on rvalid, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (rvalid) begin
            rdata_d = rdata_ex;
        end
    end

    // Result register; reset takes priority over a simultaneous rvalid.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_load_extend_mux.sv
// Self-checking bench for load_extend_mux: directed literal vectors plus a
// per-cycle comparison against a byte-array load model.
module tb_load_extend_mux;

    logic        clock;
    logic        reset;
    logic [31:0] rdata;
    logic [2:0]  funct3;
    logic [1:0]  byte_off;
    logic        rvalid;
    logic [31:0] rdata_ex;
    logic        key_hit;
    logic [31:0] rdata_q;

    int tests = 0;
    int fails = 0;
    logic        chk_en = 1'b0;
    logic [31:0] exp_q;

    load_extend_mux dut (
        .clock    (clock),
        .reset    (reset),
        .rdata    (rdata),
        .funct3   (funct3),
        .byte_off (byte_off),
        .rvalid   (rvalid),
        .rdata_ex (rdata_ex),
        .key_hit  (key_hit),
        .rdata_q  (rdata_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Load model: view the word as four bytes and let native signed types extend.
    function automatic logic [31:0] golden(input logic [31:0] w, input logic [2:0] f,
                                           input logic [1:0] off);
        logic [7:0]     by [4];
        logic [15:0]    hw;
        byte signed     sb;
        shortint signed sh;
        int             r;
        by[0] = w[7:0];
        by[1] = w[15:8];
        by[2] = w[23:16];
        by[3] = w[31:24];
        hw = (off == 2'd3) ? {8'h00, by[3]} : {by[off + 2'd1], by[off]};
        r = 0;
        case (f)
            3'd0: begin sb = by[off]; r = sb; end
            3'd1: begin sh = hw; r = sh; end
            3'd2: r = w;
            3'd4: r = {24'h0, by[off]};
            3'd5: r = {16'h0, hw};
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic logic golden_hit(input logic [2:0] f);
        return (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
    endfunction

    // Expected register contents.
    always @(posedge clock) begin
        if (reset) exp_q <= 32'h0;
        else if (rvalid) exp_q <= golden(rdata, funct3, byte_off);
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            tests++;
            if (rdata_ex !== golden(rdata, funct3, byte_off)) begin
                fails++;
                $display("FAIL model_rdata_ex f3=%b off=%0d rdata=%h got %h want %h",
                         funct3, byte_off, rdata, rdata_ex, golden(rdata, funct3, byte_off));
            end
            tests++;
            if (key_hit !== golden_hit(funct3)) begin
                fails++;
                $display("FAIL model_key_hit f3=%b got %b want %b", funct3, key_hit, golden_hit(funct3));
            end
            tests++;
            if (rdata_q !== exp_q) begin
                fails++;
                $display("FAIL model_rdata_q got %h want %h", rdata_q, exp_q);
            end
        end
    end

    task automatic apply(input logic [31:0] rd, input logic [2:0] f, input logic [1:0] off,
                         input logic v);
        @(posedge clock);
        #1;
        rdata    = rd;
        funct3   = f;
        byte_off = off;
        rvalid   = v;
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    // Apply a combinational vector and check it mid-cycle against literals.
    task automatic lit(input string name, input logic [2:0] f, input logic [1:0] off,
                       input logic [31:0] want, input logic want_hit);
        apply(32'h8421F0E7, f, off, 1'b0);
        @(negedge clock);
        check32(name, rdata_ex, want);
        check1({name, "_hit"}, key_hit, want_hit);
    endtask

    initial begin
        reset    = 1'b1;
        rdata    = 32'h0;
        funct3   = 3'd0;
        byte_off = 2'd0;
        rvalid   = 1'b0;
        repeat (2) @(posedge clock);
        chk_en = 1'b1;
        #1 reset = 1'b0;
        @(negedge clock);
        check32("reset_q", rdata_q, 32'h0);

        // Byte loads
        lit("lb_off0",  3'd0, 2'd0, 32'hFFFFFFE7, 1'b1);
        lit("lb_off1",  3'd0, 2'd1, 32'hFFFFFFF0, 1'b1);
        lit("lb_off2",  3'd0, 2'd2, 32'h00000021, 1'b1);
        lit("lb_off3",  3'd0, 2'd3, 32'hFFFFFF84, 1'b1);
        lit("lbu_off0", 3'd4, 2'd0, 32'h000000E7, 1'b1);
        lit("lbu_off3", 3'd4, 2'd3, 32'h00000084, 1'b1);
        // Halfword loads
        lit("lh_off0",  3'd1, 2'd0, 32'hFFFFF0E7, 1'b1);
        lit("lh_off2",  3'd1, 2'd2, 32'hFFFF8421, 1'b1);
        lit("lh_off3",  3'd1, 2'd3, 32'h00000084, 1'b1);
        lit("lhu_off2", 3'd5, 2'd2, 32'h00008421, 1'b1);
        // Word and default keys
        for (int o = 0; o < 4; o++) lit("lw", 3'd2, 2'(o), 32'h8421F0E7, 1'b1);
        lit("key011", 3'd3, 2'd1, 32'h0, 1'b0);
        lit("key110", 3'd6, 2'd2, 32'h0, 1'b0);
        lit("key111", 3'd7, 2'd0, 32'h0, 1'b0);

        // Capture and hold
        apply(32'h8421F0E7, 3'd0, 2'd1, 1'b1);
        apply(32'h0, 3'd0, 2'd1, 1'b0);
        @(negedge clock);
        check32("capture", rdata_q, 32'hFFFFFFF0);
        apply(32'h0, 3'd2, 2'd0, 1'b0);
        @(negedge clock);
        check32("hold", rdata_q, 32'hFFFFFFF0);

        // Reset wins over rvalid
        apply(32'h8421F0E7, 3'd2, 2'd0, 1'b1);
        reset = 1'b1;
        apply(32'h8421F0E7, 3'd2, 2'd0, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check32("reset_priority", rdata_q, 32'h0);

        // Random sweep, checked by the per-cycle model comparison
        for (int n = 0; n < 1000; n++) begin
            apply($urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        end

        @(negedge clock);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_extend_mux.md
Name: load_extend_mux

Overview:
- Load-data formatter sitting between the AXI read-data channel and the writeback register in the LSU.
- Selects the byte or halfword addressed by the low address bits. Applies RV32 load semantics (lb/lh/lw/lbu/lhu) through a keyed mux with a default value, plus sign extension.
- Publishes the formatted value combinationally and also as a register captured on read-data valid.

Parameters:
- DATA_LEN, 32, width of rdata and of both result outputs; only 32 is required.
- NR_KEY, 5, number of key/data pairs in the keyed mux.
- KEY_LEN, 3, key width, equal to the funct3 width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- rdata  in  32  raw bus read word.
- funct3  in  3  load type key: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- byte_off  in  2  effective-address bits [1:0].
- rvalid  in  1  read-data valid; capture strobe.
- rdata_ex  out  32  combinational formatted result.
- key_hit  out  1  combinational; 1 when funct3 matches one of the 5 keys.
- rdata_q  out  32  registered formatted result.

Behaviour:
- Lane extraction:
  - shift = byte_off*8.
  - b8 = rdata[shift+7:shift].
  - h16 = rdata[shift+15:shift].
  - Bits of h16 above rdata bit 31 read as 0. For byte_off=3, h16 = {8'h00, rdata[31:24]}.
- Sign extension (sext sub-function, input width W to output 32): replicate bit W-1 into bits 31:W.
  - i8 = sext(b8).
  - i16 = sext(h16). For byte_off=3, h16 bit 15 is 0, so the result is zero-extended.
- Keyed mux (MuxKeyInternal function), output rdata_ex:
  - 000 -> i8.
  - 001 -> i16.
  - 010 -> rdata, byte_off ignored.
  - 100 -> {24'b0, b8}.
  - 101 -> {16'b0, h16}.
  - Any other key (011, 110, 111) -> default 32'h0 and key_hit=0.
  - Keys are unique, so no priority is needed.
- rdata_ex and key_hit are purely combinational, with zero latency from rdata/funct3/byte_off.
- Register rdata_q, at each posedge:
  - reset=1 -> rdata_q=0. Reset wins over a simultaneous rvalid.
  - else rvalid=1 -> rdata_q takes the rdata_ex value present in that cycle. Latency is 1 cycle.
  - else rdata_q holds.
- Reset values: rdata_q=0. rdata_ex and key_hit have no reset; they follow their inputs.
- Misaligned accesses:
  - Not trapped by this block. lw ignores byte_off.
  - lh/lhu at byte_off=3 return only the top byte, zero-filled.
- No X propagation for any funct3/byte_off combination when rdata is known.

Test Plan:
- Byte loads, rdata=32'h8421F0E7:
  - funct3=000, byte_off 0/1/2/3 -> rdata_ex 32'hFFFFFFE7 / 32'hFFFFFFF0 / 32'h00000021 / 32'hFFFFFF84.
  - funct3=100, byte_off 0/3 -> 32'h000000E7 / 32'h00000084.
  - key_hit=1 throughout.
- Halfword loads, rdata=32'h8421F0E7:
  - funct3=001, byte_off 0 -> 32'hFFFFF0E7; byte_off 2 -> 32'hFFFF8421; byte_off 3 -> 32'h00000084.
  - funct3=101, byte_off 2 -> 32'h00008421.
- Word and default keys:
  - funct3=010, byte_off 0..3 -> rdata_ex always 32'h8421F0E7.
  - funct3=011/110/111 -> rdata_ex=32'h0, key_hit=0.
- Capture:
  - After reset deassert, rdata_q=0.
  - Drive funct3=000, byte_off=1, rvalid=1 for one cycle -> next cycle rdata_q=32'hFFFFFFF0.
  - Then change rdata to 32'h0 with rvalid=0 -> rdata_q stays 32'hFFFFFFF0.
- Reset priority: rdata_q nonzero, assert reset and rvalid together with valid load data -> next cycle rdata_q=0.
- Random sweep: 1000 random rdata/funct3/byte_off vectors checked against a golden model of the rules above, with rvalid randomly toggled to check capture and hold.
